// File: rtl/alu_result_buffer.sv
// alu_result_buffer: FIFO capturing ALU results and flags, with sticky flag status.
// Define ALU_RESULT_BUFFER_BYPASS_EN for a zero-latency path when the buffer is empty.
module alu_result_buffer #(
   parameter int WORD_SIZE = 16,
   parameter int DEPTH     = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WORD_SIZE-1:0]       in_out,
   input  logic [2:0]                 in_flags,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WORD_SIZE-1:0]       out_data,
   output logic [2:0]                 out_flags,
   output logic [$clog2(DEPTH):0]     count,
   output logic [2:0]                 status,
   input  logic                       clr_status
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WORD_SIZE+2:0] r_mem [DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [CW-1:0]        r_count;
   logic [2:0]           r_status;
   logic                 w_bypass;
   logic                 w_accept;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_empty;
   logic [WORD_SIZE+2:0] w_head;
`ifdef ALU_RESULT_BUFFER_BYPASS_EN
   assign w_bypass = w_empty && in_valid && out_ready;
`else
   assign w_bypass = 1'b0;
`endif
   assign w_empty  = (r_count == '0);
   assign in_ready = (r_count != CW'(DEPTH));
   assign w_accept = in_valid && in_ready;
   // A bypassed result is accepted (updates status) but never stored.
   assign w_push   = w_accept && !w_bypass;
   assign w_pop    = !w_empty && out_ready;
   assign w_head   = r_mem[r_rd_ptr];
   assign out_valid = !w_empty || w_bypass;
   assign out_data  = w_bypass ? in_out : (w_empty ? '0 : w_head[WORD_SIZE-1:0]);
   assign out_flags = w_bypass ? in_flags : (w_empty ? '0 : w_head[WORD_SIZE+2:WORD_SIZE]);
   assign count     = r_count;
   assign status    = r_status;
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {in_flags, in_out};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_status <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (clr_status) r_status <= w_accept ? in_flags : 3'b000;
         else if (w_accept) r_status <= r_status | in_flags;
      end
   end
endmodule
